// File: rtl/nzcv_flag_unit.sv
// NZCV condition-code producer: computes flags from EX results, holds them in a
// pending stage and then the architectural register, and keeps a shadow copy for interrupts.
module nzcv_flag_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  input  logic             set_flags_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] result_i,
  input  logic             carry_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             save_i,
  input  logic             restore_i,
  output logic             negative_o,
  output logic             zero_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic [3:0]       nzcv_fwd_o,
  output logic             pending_o
);

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_LOGIC = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;

  logic [3:0] arch_q;
  logic [3:0] pend_q;
  logic [3:0] shadow_q;
  logic       pend_valid_q;

  logic [3:0] new_flags;
  logic       op_defined;
  logic       capture;
  logic       commit;

  logic a_msb, b_msb, r_msb;
  assign a_msb = a_i[WIDTH-1];
  assign b_msb = b_i[WIDTH-1];
  assign r_msb = result_i[WIDTH-1];

  // Only the sign bits of the operands matter for overflow detection.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{a_i[WIDTH-2:0], b_i[WIDTH-2:0]};

  // Flags that this op leaves alone come from the newest value, i.e. the one
  // about to commit when an update is still pending.
  assign nzcv_fwd_o = pend_valid_q ? pend_q : arch_q;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    new_flags  = nzcv_fwd_o;
    op_defined = 1'b1;
    new_flags[3] = r_msb;
    new_flags[2] = (result_i == '0);
    case (op_i)
      OP_ADD: begin
        new_flags[1] = carry_i;
        new_flags[0] = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        new_flags[1] = carry_i;
        new_flags[0] = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_LOGIC: ;
      OP_SHIFT: new_flags[1] = carry_i;
      default:  op_defined = 1'b0;
    endcase
  end

  // Restore wins over both pipeline stages; flush wins over stall.
  assign capture = valid_i && set_flags_i && op_defined && !stall_i && !flush_i && !restore_i;
  assign commit  = pend_valid_q && !stall_i && !flush_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      arch_q       <= '0;
      pend_q       <= '0;
      shadow_q     <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make save+restore a true swap, since both read pre-edge values.
      if (save_i) shadow_q <= arch_q;

      if (restore_i)   arch_q <= shadow_q;
      else if (commit) arch_q <= pend_q;

      if (capture) pend_q <= new_flags;

      if (restore_i || flush_i) pend_valid_q <= 1'b0;
      else if (!stall_i)        pend_valid_q <= capture;
    end
  end

  assign negative_o = arch_q[3];
  assign zero_o     = arch_q[2];
  assign carry_o    = arch_q[1];
  assign overflow_o = arch_q[0];
  assign pending_o  = pend_valid_q;

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Self-checking bench for nzcv_flag_unit: directed vector table, reset corner,
// then randomized traffic against a flag model built from signed arithmetic.
module tb_nzcv_flag_unit;

  localparam int W = 16;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          valid_i, set_flags_i;
  logic [2:0]    op_i;
  logic [W-1:0]  a_i, b_i, result_i;
  logic          carry_i, stall_i, flush_i, save_i, restore_i;
  logic          negative_o, zero_o, carry_o, overflow_o;
  logic [3:0]    nzcv_fwd_o;
  logic          pending_o;

  int checks = 0;
  int errors = 0;

  nzcv_flag_unit #(.WIDTH(W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .set_flags_i(set_flags_i),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .result_i(result_i), .carry_i(carry_i),
    .stall_i(stall_i), .flush_i(flush_i), .save_i(save_i), .restore_i(restore_i),
    .negative_o(negative_o), .zero_o(zero_o), .carry_o(carry_o), .overflow_o(overflow_o),
    .nzcv_fwd_o(nzcv_fwd_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         valid, setf;
    logic [2:0]   op;
    logic [W-1:0] a, b, res;
    logic         cy, stall, flush, save, restore;
    logic         e_pend;
    logic [3:0]   e_fwd, e_arch;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    valid_i = v.valid; set_flags_i = v.setf; op_i = v.op;
    a_i = v.a; b_i = v.b; result_i = v.res; carry_i = v.cy;
    stall_i = v.stall; flush_i = v.flush; save_i = v.save; restore_i = v.restore;
  endtask

  task automatic check_all(input string tag, input logic ep, input logic [3:0] ef, input logic [3:0] ea);
    check({tag, " pending"}, {3'b0, pending_o}, {3'b0, ep});
    check({tag, " fwd"}, nzcv_fwd_o, ef);
    check({tag, " arch"}, {negative_o, zero_o, carry_o, overflow_o}, ea);
  endtask

  // Reference flags from signed/unsigned arithmetic rather than bit rules.
  function automatic logic [3:0] model_flags(input logic [2:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [W-1:0] r,
                                             input logic cy, input logic [3:0] fwd);
    int sa, sb, s;
    logic n, z, c, v;
    sa = int'($signed(a));
    sb = int'($signed(b));
    n = (r >= 16'h8000);
    z = (r == 0);
    c = fwd[1];
    v = fwd[0];
    if (op == 3'd0) begin
      s = sa + sb; c = cy; v = (s > 32767) || (s < -32768);
    end else if (op == 3'd1) begin
      s = sa - sb; c = cy; v = (s > 32767) || (s < -32768);
    end else if (op == 3'd3) begin
      c = cy;
    end
    return {n, z, c, v};
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return W'($urandom);
    endcase
  endfunction

  vec_t idle_v;
  logic [3:0] m_arch, m_shadow, m_fwd, m_next_arch;
  logic [3:0] m_q[$];
  vec_t rv;

  initial begin
    idle_v = '{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0, 0,4'h0,4'h0};
    drive(idle_v);
    reset_i = 1'b1;
    #1;
    check_all("reset", 1'b0, 4'b0000, 4'b0000);
    #8 reset_i = 1'b0;

    // valid setf op a b res cy stall flush save restore | pend fwd arch
    tbl.push_back('{1,1,3'd0,16'h7FFF,16'h0001,16'h8000,0,0,0,0,0, 1,4'b1001,4'b0000});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           0,4'b1001,4'b1001});
    tbl.push_back('{1,1,3'd1,16'h5,16'h5,16'h0,1,0,0,0,0,           1,4'b0110,4'b1001});
    tbl.push_back('{1,1,3'd2,16'h0,16'h0,16'h00F0,0,0,0,0,0,        1,4'b0010,4'b0110});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           0,4'b0010,4'b0010});
    tbl.push_back('{1,1,3'd0,16'h1,16'h1,16'h2,0,0,0,0,0,           1,4'b0000,4'b0010});
    tbl.push_back('{1,1,3'd0,16'h0,16'h0,16'h0,0,1,0,0,0,           1,4'b0000,4'b0010});
    tbl.push_back('{1,1,3'd0,16'h0,16'h0,16'h0,0,1,0,0,0,           1,4'b0000,4'b0010});
    tbl.push_back('{1,1,3'd0,16'h0,16'h0,16'h0,0,1,0,0,0,           1,4'b0000,4'b0010});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           0,4'b0000,4'b0000});
    tbl.push_back('{1,1,3'd3,16'h0,16'h0,16'h8000,1,0,0,0,0,        1,4'b1010,4'b0000});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           0,4'b1010,4'b1010});
    tbl.push_back('{1,1,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           1,4'b0100,4'b1010});
    tbl.push_back('{1,1,3'd1,16'h5,16'h5,16'h0,1,0,1,0,0,           0,4'b1010,4'b1010});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           0,4'b1010,4'b1010});
    tbl.push_back('{1,1,3'd0,16'h7FFF,16'h0001,16'h8000,0,0,0,0,0, 1,4'b1001,4'b1010});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           0,4'b1001,4'b1001});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,1,0,           0,4'b1001,4'b1001});
    tbl.push_back('{1,1,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           1,4'b0100,4'b1001});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           0,4'b0100,4'b0100});
    tbl.push_back('{1,1,3'd0,16'h1,16'h1,16'h2,0,0,0,0,0,           1,4'b0000,4'b0100});
    tbl.push_back('{1,1,3'd1,16'h5,16'h5,16'h0,1,0,0,0,1,           0,4'b1001,4'b1001});
    tbl.push_back('{1,1,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           1,4'b0100,4'b1001});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,0,           0,4'b0100,4'b0100});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,1,1,           0,4'b1001,4'b1001});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,0,0,0,1,           0,4'b0100,4'b0100});
    tbl.push_back('{1,0,3'd0,16'h7FFF,16'h0001,16'h8000,0,0,0,0,0, 0,4'b0100,4'b0100});
    tbl.push_back('{1,1,3'd7,16'h0,16'h0,16'h8000,1,0,0,0,0,        0,4'b0100,4'b0100});
    tbl.push_back('{1,1,3'd4,16'h0,16'h0,16'h8000,1,0,0,0,0,        0,4'b0100,4'b0100});
    tbl.push_back('{0,1,3'd0,16'h7FFF,16'h0001,16'h8000,0,0,0,0,0, 0,4'b0100,4'b0100});
    tbl.push_back('{1,1,3'd0,16'h8000,16'h8000,16'h0,1,0,0,0,0,    1,4'b0111,4'b0100});
    tbl.push_back('{0,0,3'd0,16'h0,16'h0,16'h0,0,1,1,0,0,           0,4'b0100,4'b0100});

    @(posedge clk_i); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk_i); #1;
      check_all($sformatf("vec%0d", i), tbl[i].e_pend, tbl[i].e_fwd, tbl[i].e_arch);
    end

    // Asynchronous reset while an update is pending must clear everything at once.
    drive('{1,1,3'd0,16'h7FFF,16'h0001,16'h8000,0,0,0,0,0, 0,4'h0,4'h0});
    @(posedge clk_i); #1;
    check_all("pre_reset", 1'b1, 4'b1001, 4'b0100);
    drive(idle_v);
    #2 reset_i = 1'b1;
    #1 check_all("async_reset", 1'b0, 4'b0000, 4'b0000);
    #1 reset_i = 1'b0;
    @(posedge clk_i); #1;
    check_all("post_reset", 1'b0, 4'b0000, 4'b0000);

    // Randomized traffic; model state follows the reset just applied.
    m_arch = '0; m_shadow = '0; m_q.delete();
    for (int i = 0; i < 3000; i++) begin
      rv = idle_v;
      rv.valid = ($urandom_range(0, 9) < 8);
      rv.setf  = ($urandom_range(0, 9) < 8);
      rv.op    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
      rv.a     = pick_operand();
      rv.b     = pick_operand();
      if (rv.op == 3'd0) {rv.cy, rv.res} = {1'b0, rv.a} + {1'b0, rv.b};
      else if (rv.op == 3'd1) begin
        rv.res = rv.a - rv.b;
        rv.cy  = (rv.a >= rv.b);
      end else begin
        rv.res = ($urandom_range(0, 3) == 0) ? 16'h0 : W'($urandom);
        rv.cy  = 1'($urandom);
      end
      rv.stall   = ($urandom_range(0, 4) == 0);
      rv.flush   = ($urandom_range(0, 9) == 0);
      rv.save    = ($urandom_range(0, 11) == 0);
      rv.restore = ($urandom_range(0, 11) == 0);
      drive(rv);

      m_fwd = (m_q.size() != 0) ? m_q[0] : m_arch;
      m_next_arch = m_arch;
      if (rv.restore) m_next_arch = m_shadow;
      else if (m_q.size() != 0 && !rv.stall && !rv.flush) m_next_arch = m_q[0];
      if (rv.save) m_shadow = m_arch;
      m_arch = m_next_arch;
      if (rv.restore || rv.flush) m_q.delete();
      else if (!rv.stall) begin
        m_q.delete();
        if (rv.valid && rv.setf && rv.op < 3'd4)
          m_q.push_back(model_flags(rv.op, rv.a, rv.b, rv.res, rv.cy, m_fwd));
      end

      @(posedge clk_i); #1;
      m_fwd = (m_q.size() != 0) ? m_q[0] : m_arch;
      check_all($sformatf("rand%0d", i), m_q.size() != 0, m_fwd, m_arch);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
